// File: rtl/kan_tda_job_scheduler_pkg.sv
// Shared types and sizing helpers for the KAN/TDA job scheduler.
package kan_tda_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        TDA_WAIT
    } sched_state_e;

    localparam int unsigned DEFAULT_TILE_W = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/kan_tda_job_scheduler_if.sv
// Job descriptor plus core/unit start/done lines. master = host side and
// core/unit array, slave = scheduler.
interface kan_tda_job_scheduler_if
    import kan_tda_sched_pkg::*;
#(
    parameter int unsigned NUM_KAN_CORES = 16,
    parameter int unsigned NUM_TDA_UNITS = 4,
    parameter int unsigned TILE_W        = DEFAULT_TILE_W,
    parameter int unsigned CNT_W         = cnt_width(NUM_KAN_CORES)
);
    logic                     start;
    logic [NUM_KAN_CORES-1:0] kan_mask;
    logic [NUM_TDA_UNITS-1:0] tda_mask;
    logic [TILE_W-1:0]        num_tiles;
    logic [CNT_W-1:0]         max_active;
    logic [NUM_KAN_CORES-1:0] kan_start;
    logic [TILE_W-1:0]        kan_tile_id;
    logic [NUM_KAN_CORES-1:0] kan_done;
    logic [NUM_TDA_UNITS-1:0] tda_start;
    logic [NUM_TDA_UNITS-1:0] tda_done;
    logic                     busy;
    logic                     computation_complete;
    logic [CNT_W-1:0]         active_count;

    modport master (
        output start, kan_mask, tda_mask, num_tiles, max_active, kan_done, tda_done,
        input  kan_start, kan_tile_id, tda_start, busy, computation_complete, active_count
    );

    modport slave (
        input  start, kan_mask, tda_mask, num_tiles, max_active, kan_done, tda_done,
        output kan_start, kan_tile_id, tda_start, busy, computation_complete, active_count
    );
endinterface

// File: rtl/kan_tda_job_scheduler_rr_picker.sv
// Combinational round-robin first-one finder: grants the first eligible
// bit at or after the pointer, wrapping at N.
module kan_rr_picker #(
    parameter int unsigned N     = 16,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o
);
    always_comb begin
        int unsigned       idx;
        logic [PTR_W-1:0]  sel;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PTR_W'(idx);
            if (!valid_o && eligible_i[sel]) begin
                grant_o[sel] = 1'b1;
                valid_o      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/kan_tda_job_scheduler.sv
// Job sequencer: dispatches KAN tiles round-robin under a power cap, then
// launches the enabled TDA units and flags completion.
module kan_tda_job_scheduler
    import kan_tda_sched_pkg::*;
#(
    parameter int unsigned NUM_KAN_CORES = 16,
    parameter int unsigned NUM_TDA_UNITS = 4,
    parameter int unsigned TILE_W        = DEFAULT_TILE_W,
    parameter int unsigned CNT_W         = cnt_width(NUM_KAN_CORES)
) (
    input logic                    clk,
    input logic                    rst,
    kan_tda_job_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_KAN_CORES);

    sched_state_e             state_q;
    logic [NUM_KAN_CORES-1:0] kan_mask_q, busy_vec_q, busy_vec_d, kan_start_q;
    logic [NUM_KAN_CORES-1:0] eligible, grant, kan_left;
    logic [NUM_TDA_UNITS-1:0] tda_mask_q, tda_seen_q, tda_start_q;
    logic [TILE_W-1:0]        tiles_q, tile_cnt_q, kan_tile_id_q;
    logic [CNT_W-1:0]         cap_q, active_count_q, active_count_d;
    logic [PTR_W-1:0]         ptr_q, gidx, ptr_next;
    logic                     grant_valid, dispatch, last_tile, tda_all, kan_drained;
    logic                     busy_q, complete_q;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_KAN_CORES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_KAN_CORES; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    kan_rr_picker #(
        .N     (NUM_KAN_CORES),
        .PTR_W (PTR_W)
    ) u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .valid_o    (grant_valid)
    );

    // The first tile goes out in the start cycle, so IDLE picks from the live mask.
    always_comb begin
        eligible = (state_q == IDLE) ? bus.kan_mask : (kan_mask_q & ~busy_vec_q);
        dispatch = grant_valid &&
                   (((state_q == IDLE) && bus.start && (bus.num_tiles != '0)) ||
                    ((state_q == DISPATCH) && (active_count_q < cap_q) &&
                     (tile_cnt_q != tiles_q)));
        last_tile = (state_q == IDLE) ? (bus.num_tiles == TILE_W'(1))
                                      : (tile_cnt_q + 1'b1 == tiles_q);
        gidx = '0;
        for (int unsigned i = 0; i < NUM_KAN_CORES; i++) begin
            if (grant[i]) begin
                gidx = PTR_W'(i);
            end
        end
        ptr_next       = (gidx == PTR_W'(NUM_KAN_CORES - 1)) ? '0 : gidx + 1'b1;
        kan_left       = busy_vec_q & ~bus.kan_done;
        busy_vec_d     = kan_left | (dispatch ? grant : '0);
        active_count_d = popcnt(busy_vec_d);
        kan_drained    = (kan_left == '0);
        tda_all        = (((tda_seen_q | bus.tda_done) & tda_mask_q) == tda_mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            kan_mask_q     <= '0;
            tda_mask_q     <= '0;
            tiles_q        <= '0;
            cap_q          <= '0;
            tile_cnt_q     <= '0;
            ptr_q          <= '0;
            busy_vec_q     <= '0;
            tda_seen_q     <= '0;
            kan_start_q    <= '0;
            kan_tile_id_q  <= '0;
            tda_start_q    <= '0;
            busy_q         <= 1'b0;
            complete_q     <= 1'b0;
            active_count_q <= '0;
        end else begin
            kan_start_q    <= '0;
            tda_start_q    <= '0;
            busy_vec_q     <= busy_vec_d;
            active_count_q <= active_count_d;
            if (dispatch) begin
                kan_start_q   <= grant;
                kan_tile_id_q <= (state_q == IDLE) ? '0 : tile_cnt_q;
                ptr_q         <= ptr_next;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        kan_mask_q <= bus.kan_mask;
                        tda_mask_q <= bus.tda_mask;
                        tiles_q    <= bus.num_tiles;
                        cap_q      <= (bus.max_active == '0) ? CNT_W'(1) : bus.max_active;
                        complete_q <= 1'b0;
                        tile_cnt_q <= dispatch ? TILE_W'(1) : '0;
                        tda_seen_q <= '0;
                        if (dispatch) begin
                            busy_q  <= 1'b1;
                            state_q <= last_tile ? DRAIN : DISPATCH;
                        end else if (bus.tda_mask != '0) begin
                            busy_q      <= 1'b1;
                            tda_start_q <= bus.tda_mask;
                            state_q     <= TDA_WAIT;
                        end else begin
                            complete_q <= 1'b1;
                        end
                    end
                end
                DISPATCH: begin
                    if (dispatch) begin
                        tile_cnt_q <= tile_cnt_q + 1'b1;
                        if (last_tile) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (kan_drained) begin
                        if (tda_mask_q != '0) begin
                            tda_seen_q  <= '0;
                            tda_start_q <= tda_mask_q;
                            state_q     <= TDA_WAIT;
                        end else begin
                            complete_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                TDA_WAIT: begin
                    tda_seen_q <= tda_seen_q | bus.tda_done;
                    if (tda_all) begin
                        complete_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.kan_start            = kan_start_q;
    assign bus.kan_tile_id          = kan_tile_id_q;
    assign bus.tda_start            = tda_start_q;
    assign bus.busy                 = busy_q;
    assign bus.computation_complete = complete_q;
    assign bus.active_count         = active_count_q;
endmodule

// File: tb/tb_kan_tda_job_scheduler.sv
// Directed bench for kan_tda_job_scheduler with a simple KAN core responder.
module tb_kan_tda_job_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kan_tda_job_scheduler_if #(.NUM_KAN_CORES(16), .NUM_TDA_UNITS(4), .TILE_W(8)) bus ();

    kan_tda_job_scheduler #(.NUM_KAN_CORES(16), .NUM_TDA_UNITS(4), .TILE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int cyc;
        int core;
        int id;
    } disp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ncyc    = 0;
    int          s0      = 0;
    int          lat[16];
    int          cnt[16];
    int          max_act = 0;
    logic        stray   = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] allowed = 16'hFFFF;
    logic [15:0] resp_done = '0;
    logic [15:0] man_done  = '0;
    disp_t       log_q[$];

    assign bus.kan_done = resp_done | man_done;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Core model: each started core pulses kan_done lat[core] cycles later.
    always @(negedge clk) begin
        if (stat_clr) begin
            log_q.delete();
            max_act = 0;
            stray   = 1'b0;
        end
        if (rst) begin
            for (int j = 0; j < 16; j++) cnt[j] = 0;
            resp_done = '0;
        end else begin
            for (int j = 0; j < 16; j++) begin
                resp_done[j] = 1'b0;
                if (cnt[j] != 0) begin
                    cnt[j] = cnt[j] - 1;
                    if (cnt[j] == 0) resp_done[j] = 1'b1;
                end
            end
            for (int j = 0; j < 16; j++) begin
                if (bus.kan_start[j]) begin
                    cnt[j] = lat[j];
                    log_q.push_back('{ncyc, j, int'(bus.kan_tile_id)});
                end
            end
            if ((bus.kan_start & ~allowed) != '0) stray = 1'b1;
            if (int'(bus.active_count) > max_act) max_act = int'(bus.active_count);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic at_cycle(input int k);
        while (ncyc - s0 < k) tick();
    endtask

    task automatic launch(input logic [15:0] km, input logic [3:0] tm,
                          input logic [7:0] nt, input logic [4:0] ma);
        bus.kan_mask   = km;
        bus.tda_mask   = tm;
        bus.num_tiles  = nt;
        bus.max_active = ma;
        bus.start      = 1'b1;
        stat_clr       = 1'b1;
        s0             = ncyc;
        tick();
        bus.start      = 1'b0;
        stat_clr       = 1'b0;
    endtask

    task automatic wait_complete(input int budget, output int c);
        int n;
        n = 0;
        while (!bus.computation_complete && n < budget) begin
            tick();
            n++;
        end
        check("complete_timeout", 32'(bus.computation_complete), 32'(1));
        c = ncyc - s0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_kan_start"}, 32'(bus.kan_start), 32'(0));
        check({tag, "_tile_id"},   32'(bus.kan_tile_id), 32'(0));
        check({tag, "_tda_start"}, 32'(bus.tda_start), 32'(0));
        check({tag, "_busy"},      32'(bus.busy), 32'(0));
        check({tag, "_complete"},  32'(bus.computation_complete), 32'(0));
        check({tag, "_active"},    32'(bus.active_count), 32'(0));
    endtask

    initial begin
        int c;
        bus.start      = 1'b0;
        bus.kan_mask   = '0;
        bus.tda_mask   = '0;
        bus.num_tiles  = '0;
        bus.max_active = '0;
        bus.tda_done   = '0;
        for (int j = 0; j < 16; j++) lat[j] = 3;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Four tiles on a fully enabled array; a second start mid-job is ignored.
        allowed = 16'hFFFF;
        launch(16'hFFFF, 4'h0, 8'd4, 5'd16);
        check("t1_busy_c1", 32'(bus.busy), 32'(1));
        check("t1_start_c1", 32'(bus.kan_start), 32'h0001);
        at_cycle(2);
        bus.start = 1'b1; bus.num_tiles = 8'd9; bus.kan_mask = 16'h00F0;
        tick();
        bus.start = 1'b0;
        wait_complete(100, c);
        check("t1_complete_cycle", 32'(c), 32'(8));
        check("t1_busy_end", 32'(bus.busy), 32'(0));
        check("t1_dispatches", 32'(log_q.size()), 32'(4));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t1_core", 32'(log_q[k].core), 32'(k));
            check("t1_id", 32'(log_q[k].id), 32'(k));
            check("t1_cycle", 32'(log_q[k].cyc - s0), 32'(k + 1));
        end

        // Cap of 2 with mixed latencies; pointer resumes at core 4.
        for (int j = 0; j < 16; j++) lat[j] = 1 + (j * 7) % 10;
        launch(16'hFFFF, 4'h0, 8'd20, 5'd2);
        wait_complete(600, c);
        check("t2_dispatches", 32'(log_q.size()), 32'(20));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t2_core", 32'(log_q[k].core), 32'((4 + k) % 16));
            check("t2_id", 32'(log_q[k].id), 32'(k));
        end
        check("t2_max_active", 32'(max_act), 32'(2));
        check("t2_active_end", 32'(bus.active_count), 32'(0));

        // Only cores 0 and 15 enabled; pointer at 8 so core 15 goes first.
        for (int j = 0; j < 16; j++) lat[j] = 3;
        allowed = 16'h8001;
        launch(16'h8001, 4'h0, 8'd5, 5'd16);
        wait_complete(200, c);
        check("t3_stray", 32'(stray), 32'(0));
        check("t3_dispatches", 32'(log_q.size()), 32'(5));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t3_core", 32'(log_q[k].core), (k % 2 == 0) ? 32'(15) : 32'(0));
            check("t3_id", 32'(log_q[k].id), 32'(k));
        end
        allowed = 16'hFFFF;

        // TDA-only job.
        launch(16'hFFFF, 4'hF, 8'd0, 5'd4);
        check("t4_tda_start_c1", 32'(bus.tda_start), 32'hF);
        check("t4_busy_c1", 32'(bus.busy), 32'(1));
        tick();
        check("t4_tda_start_c2", 32'(bus.tda_start), 32'h0);
        at_cycle(5);
        bus.tda_done = 4'b1011;
        tick();
        bus.tda_done = 4'b0000;
        at_cycle(50);
        check("t4_complete_c50", 32'(bus.computation_complete), 32'(0));
        bus.tda_done = 4'b0100;
        tick();
        bus.tda_done = 4'b0000;
        check("t4_complete_c51", 32'(bus.computation_complete), 32'(1));
        check("t4_busy_c51", 32'(bus.busy), 32'(0));

        // Empty job: tiles present but no cores enabled, no TDA units.
        launch(16'h0000, 4'h0, 8'd5, 5'd4);
        check("t5_complete_c1", 32'(bus.computation_complete), 32'(1));
        check("t5_busy_c1", 32'(bus.busy), 32'(0));
        check("t5_kan_start_c1", 32'(bus.kan_start), 32'(0));

        // max_active=0 acts as 1; spurious done on idle core 5.
        launch(16'hFFFF, 4'h0, 8'd3, 5'd0);
        check("t6_complete_cleared", 32'(bus.computation_complete), 32'(0));
        check("t6_start_c1", 32'(bus.kan_start), 32'h0001);
        at_cycle(2);
        man_done = 16'h0020;
        tick();
        man_done = '0;
        check("t6_spurious_active", 32'(bus.active_count), 32'(1));
        wait_complete(100, c);
        check("t6_complete_cycle", 32'(c), 32'(15));
        check("t6_max_active", 32'(max_act), 32'(1));
        check("t6_dispatches", 32'(log_q.size()), 32'(3));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t6_core", 32'(log_q[k].core), 32'(k));
            check("t6_cycle", 32'(log_q[k].cyc - s0), 32'(1 + 5 * k));
        end

        // Reset mid-job with three cores active, then a fresh job.
        for (int j = 0; j < 16; j++) lat[j] = 20;
        launch(16'hFFFF, 4'h0, 8'd10, 5'd3);
        at_cycle(10);
        check("t7_active_c10", 32'(bus.active_count), 32'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("t7_rst");
        check("t7_dispatches", 32'(log_q.size()), 32'(3));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t7_core", 32'(log_q[k].core), 32'(3 + k));
        end
        at_cycle(12);
        man_done = 16'hFFFF;
        at_cycle(16);
        man_done = '0;
        check("t7_active_after_done", 32'(bus.active_count), 32'(0));
        check("t7_busy_after_done", 32'(bus.busy), 32'(0));
        for (int j = 0; j < 16; j++) lat[j] = 3;
        launch(16'hFFFF, 4'h0, 8'd2, 5'd16);
        wait_complete(100, c);
        check("t7b_complete_cycle", 32'(c), 32'(6));
        check("t7b_dispatches", 32'(log_q.size()), 32'(2));
        for (int k = 0; k < log_q.size(); k++) begin
            check("t7b_core", 32'(log_q[k].core), 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
